// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DATA,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [7:0] CSUM_SEED = 8'h00;
    localparam int         BYTE_W    = 8;
    localparam int         WORD_W    = 32;
    localparam int         IDX_W     = 2;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs stream bytes little-endian into a word and keeps the running XOR.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic [IDX_W-1:0]  o_idx,
    output logic [BYTE_W-1:0] o_csum,
    output logic              o_last
);

    logic [WORD_W-1:0] r_word;
    logic [IDX_W-1:0]  r_idx;
    logic [BYTE_W-1:0] r_csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_idx  <= '0;
            r_csum <= CSUM_SEED;
        end else if (i_clear) begin
            r_word <= '0;
            r_idx  <= '0;
            r_csum <= CSUM_SEED;
        end else if (i_load) begin
            r_word[{r_idx, 3'b000} +: BYTE_W] <= i_byte;
            r_idx  <= r_idx + IDX_W'(1);
            r_csum <= r_csum ^ i_byte;
        end
    end

    assign o_word = r_word;
    assign o_idx  = r_idx;
    assign o_csum = r_csum;
    assign o_last = (r_idx == IDX_W'(3));

endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte stream into instruction memory; holds the core until a
// checksummed load completes.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_last;
    logic              w_xfer;
    logic              w_n_bad;
    logic              w_clear;
    logic              w_load;
    logic              w_wlast;
    logic [31:0]       w_word;
    logic [1:0]        w_idx;
    logic [7:0]        w_csum;
    logic              w_byte_last;

    assign w_xfer  = byte_valid && byte_ready;
    assign w_n_bad = (byte_data == 8'd0) || (int'(byte_data) > DEPTH);
    assign w_clear = (r_state == ST_COUNT) && w_xfer && !w_n_bad;
    assign w_load  = (r_state == ST_DATA) && w_xfer;
    assign w_wlast = (r_addr == r_last);

    word_assembler u_asm (
        .clk     (clk),
        .rst_n   (reset),
        .i_clear (w_clear),
        .i_load  (w_load),
        .i_byte  (byte_data),
        .o_word  (w_word),
        .o_idx   (w_idx),
        .o_csum  (w_csum),
        .o_last  (w_byte_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (start) w_next = ST_COUNT;
            ST_COUNT: if (w_xfer) w_next = w_n_bad ? ST_ERR : ST_DATA;
            ST_DATA:  if (w_xfer && w_byte_last) w_next = ST_WRITE;
            ST_WRITE: w_next = w_wlast ? ST_CHECK : ST_DATA;
            ST_CHECK: begin
                if (w_xfer) w_next = (byte_data == w_csum) ? ST_DONE : ST_ERR;
            end
            ST_DONE:  if (start) w_next = ST_COUNT;
            ST_ERR:   if (start) w_next = ST_COUNT;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = (r_state == ST_COUNT) || (r_state == ST_DATA)
                  || (r_state == ST_CHECK);
        imem_we    = (r_state == ST_WRITE);
        core_hold  = (r_state != ST_DONE);
        done       = (r_state == ST_DONE);
        error      = (r_state == ST_ERR);
    end

    // The address stops at the last word so a DEPTH-word load never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr <= '0;
            r_last <= '0;
        end else if (w_clear) begin
            r_addr <= '0;
            r_last <= ADDR_W'(byte_data - 8'd1);
        end else if (imem_we && !w_wlast) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    assign imem_addr  = r_addr;
    assign imem_wdata = w_word;

    logic w_unused;
    assign w_unused = ^w_idx;

endmodule
